// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op codes, op legality,
// and the per-stage record that travels down the pipeline.
package shift_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned SHAMT_W = $clog2(DATA_W);
  localparam int unsigned OP_W    = 3;

  localparam logic [OP_W-1:0] OP_SLL = 3'b000;
  localparam logic [OP_W-1:0] OP_SRL = 3'b001;
  localparam logic [OP_W-1:0] OP_SRA = 3'b010;
  localparam logic [OP_W-1:0] OP_ROL = 3'b011;
  localparam logic [OP_W-1:0] OP_ROR = 3'b100;

  // One pipeline slot: payload plus the sidebands each log stage needs
  typedef struct packed {
    logic                 valid;
    logic [OP_W-1:0]      op;
    logic [SHAMT_W-1:0]   shamt;
    logic [DATA_W-1:0]    data;
    logic                 carry;
    logic                 fill;
    logic                 err;
  } stage_t;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op <= OP_ROR);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One log stage of the barrel shifter: conditionally moves the record's data
// by 2^STAGE and updates the running carry. Purely combinational.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned STAGE = 0
) (
  input  stage_t src,
  output stage_t dst
);

  localparam int unsigned SH = 1 << STAGE;

  logic [2*WIDTH-1:0] sra_ext;

  always_comb begin
    dst     = src;
    // SRA fill comes from the original operand MSB, not the current data
    sra_ext = {{WIDTH{src.fill}}, src.data} >> SH;
    if (!src.err && src.shamt[STAGE]) begin
      case (src.op)
        OP_SLL: begin
          dst.data  = src.data << SH;
          dst.carry = src.data[WIDTH-SH];
        end
        OP_SRL: begin
          dst.data  = src.data >> SH;
          dst.carry = src.data[SH-1];
        end
        OP_SRA: begin
          dst.data  = sra_ext[WIDTH-1:0];
          dst.carry = src.data[SH-1];
        end
        OP_ROL: begin
          dst.data  = (src.data << SH) | (src.data >> (WIDTH-SH));
          dst.carry = src.data[WIDTH-SH];
        end
        OP_ROR: begin
          dst.data  = (src.data >> SH) | (src.data << (WIDTH-SH));
          dst.carry = src.data[SH-1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter, one register per log stage, with a single global
// advance for valid/ready back-pressure.
module shift_pipe
  import shift_pkg::*;
#(
  parameter  int unsigned WIDTH = DATA_W,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_err
);

  logic   advance;
  stage_t head;
  stage_t nxt [SHW];
  stage_t rec [SHW];
  stage_t last;
  logic   unused_last;

  // Whole pipe moves or whole pipe holds; no bubble squeezing
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Operand entering stage 0
  always_comb begin
    head       = '0;
    head.valid = in_valid & advance;
    head.op    = in_op;
    head.shamt = SHAMT_W'(in_shamt);
    head.data  = DATA_W'(in_data);
    head.fill  = in_data[WIDTH-1];
    head.err   = ~op_legal(in_op);
  end

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    if (k == 0) begin : g_first
      shift_stage #(.WIDTH(WIDTH), .STAGE(k)) u_stage (.src(head), .dst(nxt[k]));
    end else begin : g_rest
      shift_stage #(.WIDTH(WIDTH), .STAGE(k)) u_stage (.src(rec[k-1]), .dst(nxt[k]));
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < SHW; k++) begin
      if (rst) begin
        rec[k] <= '0;
      end else if (advance) begin
        rec[k] <= nxt[k];
      end
    end
  end

  assign last        = rec[SHW-1];
  assign out_valid   = last.valid;
  assign out_data    = WIDTH'(last.data);
  assign out_carry   = last.carry;
  assign out_err     = last.err;
  assign unused_last = ^{last.op, last.shamt, last.fill};

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined barrel shifter with valid/ready handshaking, supporting logical, arithmetic and rotate shifts. It is the next generation of the lab's 8-bit combinational left/right, arithmetic/logical shifter. It adds rotate modes, carry-out, a one-register-per-log-stage pipeline and back-pressure. It sits between an upstream operand producer and a downstream result consumer, such as the display/LFSR datapaths, in the same design.

## Interface
Parameters:
- WIDTH, 8, data width; power of two, ≥ 2
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream operand valid
- in_ready  out  1  shifter can accept an operand this cycle
- in_data  in  WIDTH  operand
- in_shamt  in  SHW  shift amount, 0..WIDTH-1
- in_op  in  3  operation code (see Operation)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  WIDTH  shifted result
- out_carry  out  1  last bit shifted out / wrapped
- out_err  out  1  in_op was an illegal code

## Operation
- Op codes:
  - 000 SLL: shift left, zero fill
  - 001 SRL: shift right, zero fill
  - 010 SRA: shift right, MSB fill
  - 011 ROL: rotate left
  - 100 ROR: rotate right
  - 101–111 illegal: data passes unchanged, carry 0, err 1
- Shift amount 0: out_data = in_data, out_carry = 0, for every op.
- Carry for nonzero shamt s:
  - SLL: in_data[WIDTH-s]
  - SRL/SRA: in_data[s-1]
  - ROL: out_data[0]
  - ROR: out_data[WIDTH-1]
- Datapath: SHW log stages. Stage k moves data by 2^k when shamt[k]=1, otherwise passes it.
- Each stage carries these sidebands along with the data: op, remaining shamt bits, running carry, err, valid.
- Fill bit for SRA is the original operand MSB, carried as a sideband. It is not re-sampled per stage.

## Timing
- Pipeline depth is SHW registered stages. For WIDTH=8, latency is 3 cycles from in handshake to out_valid.
- Input handshake: in_valid & in_ready on an edge. Output handshake: out_valid & out_ready.
- Global advance = ~out_valid | out_ready. in_ready = advance, computed combinationally from out_valid and out_ready only.
- When advance=0, every stage register holds, including valid bits. No bubble squeeze is required.
- When advance=1, every stage shifts forward. Stage 0 loads in_valid & in_ready.
- Sustained throughput is 1 result per cycle when out_ready is held at 1.
- out_data, out_carry and out_err are undefined while out_valid=0, but must be stable while out_valid=1 and out_ready=0.
- Reset (rst=1 at an edge):
  - all valid bits clear, so out_valid=0
  - out_data=0, out_carry=0, out_err=0
  - in-flight operands are discarded, including when reset is asserted mid-stream
  - in_ready=1 in the cycle after reset
- Simultaneous output drain and input accept in the same cycle is legal and loses nothing.
- Results leave in acceptance order; no reordering.

## Structure
- Package shift_pkg holds:
  - op-code localparams (OP_SLL … OP_ROR)
  - an op-legality function
  - the stage record typedef {valid, op, shamt, data, carry, fill, err}
- Sub-module shift_stage, parameters WIDTH and STAGE (k):
  - combinational 2^k shift of one record
  - instantiated SHW times via generate
  - registers and advance logic stay in shift_pipe
- No other hierarchy.

## Test plan
All scenarios use WIDTH=8.
- in_data=8'h96, SRA, shamt=2 → after 3 cycles out_data=8'hE5, carry=1, err=0.
- in_data=8'h96, SLL, shamt=3 → out_data=8'hB0, carry=0. With SRL, shamt=7 → out_data=8'h01, carry=0.
- in_data=8'h96, ROR, shamt=1 → out_data=8'h4B, carry=0. With ROL, shamt=4 → out_data=8'h69, carry=1.
- in_op=3'b110, in_data=8'h5A, shamt=5 → out_data=8'h5A, carry=0, err=1. With shamt=0 on any legal op → data unchanged, carry=0.
- Back-pressure:
  - stream 10 random operands back-to-back
  - hold out_ready=0 for 4 cycles mid-stream
  - required: in_ready drops while out_valid=1; outputs stay stable; all 10 results match the reference model, in order, with none lost or duplicated
- Reset mid-operation: issue rst=1 for one cycle with 3 operands in flight → out_valid=0 the next cycle, no stale result ever emerges, and a new operand completes with 3-cycle latency.
